bit_destuffer: RTL

BIT_DESTUFFER -- requirements
Module: bit_destuffer

---
 rtl/bit_destuffer.sv | 97 +++++++++
 1 files changed

// File: rtl/bit_destuffer.sv
// Receive-side bit destuffer: tracks runs of equal bits inside the stuffing
// region, flags the stuff bit that must follow STUFF_LEN equal bits, and
// latches a stuff violation. All outputs are registered one clk after sp.
module bit_destuffer #(
    parameter int STUFF_LEN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sp,
    input  logic       rx_bit,
    input  logic       enable,
    input  logic       clear,
    output logic       sp_out,
    output logic       bit_out,
    output logic       isStuff,
    output logic       bit_valid,
    output logic       stuff_err,
    output logic [2:0] run_len
);

    typedef enum logic [1:0] {IDLE, COUNT, EXPECT_STUFF, ERROR} state_t;

    localparam logic [2:0] LEN = 3'(STUFF_LEN);
    // A freshly started run of one bit already satisfies a run length of one.
    localparam state_t FIRST_ST = (LEN == 3'd1) ? EXPECT_STUFF : COUNT;

    state_t state;
    logic   last_bit;

    // Run tracking FSM with registered per-bit outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_bit  <= 1'b1;
            run_len   <= 3'd0;
            sp_out    <= 1'b0;
            bit_out   <= 1'b0;
            isStuff   <= 1'b0;
            bit_valid <= 1'b0;
            stuff_err <= 1'b0;
        end else begin
            // Default per-bit pulses; a stuff bit overrides bit_valid below.
            sp_out    <= sp;
            bit_valid <= sp;
            isStuff   <= 1'b0;
            if (sp) bit_out <= rx_bit;

            if (!enable) begin
                // Outside the stuffing region: pass bits through, no tracking.
                state   <= IDLE;
                run_len <= 3'd0;
                if (clear) stuff_err <= 1'b0;
            end else if (clear || state == IDLE) begin
                // Start of a region (or restart): a simultaneous sp is the
                // first bit of the new run.
                if (clear) stuff_err <= 1'b0;
                if (sp) begin
                    last_bit <= rx_bit;
                    run_len  <= 3'd1;
                    state    <= FIRST_ST;
                end else begin
                    state    <= IDLE;
                    run_len  <= 3'd0;
                end
            end else if (sp) begin
                case (state)
                    COUNT: begin
                        if (rx_bit == last_bit) begin
                            run_len <= run_len + 3'd1;
                            if (run_len + 3'd1 == LEN) state <= EXPECT_STUFF;
                        end else begin
                            last_bit <= rx_bit;
                            run_len  <= 3'd1;
                            state    <= FIRST_ST;
                        end
                    end
                    EXPECT_STUFF: begin
                        if (rx_bit != last_bit) begin
                            // Stuff bit: dropped from payload, starts new run.
                            isStuff   <= 1'b1;
                            bit_valid <= 1'b0;
                            last_bit  <= rx_bit;
                            run_len   <= 3'd1;
                            state     <= FIRST_ST;
                        end else begin
                            // Violation: run_len stays saturated at LEN.
                            stuff_err <= 1'b1;
                            state     <= ERROR;
                        end
                    end
                    default: ;  // ERROR holds run_len; bits still pass through
                endcase
            end
        end
    end

endmodule
